// File: rtl/cpu_run_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_run_ctrl
//
// Owns one complete run of the pipelined CPU:
//   IDLE -> LOAD : stream words into instruction memory, CPU held in reset
//   LOAD -> RUN  : CPU enabled for exactly run_len cycles
//   RUN  -> DUMP : CPU frozen, registers 0..REG_NUM-1 streamed out
//   DUMP -> DONE : results stable until the next start pulse
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-low reset
//   start_i, run_len_i    start pulse (IDLE/DONE only) and run length
//   ld_valid_i, ld_data_i, ld_last_i, ld_ready_o
//                         instruction load stream (valid/ready)
//   im_we_o, im_addr_o, im_wdata_o
//                         instruction memory write port
//   cpu_rst_n_o, cpu_en_o CPU reset (active-low) and global advance enable
//   rf_raddr_o, rf_rdata_i
//                         register-file combinational read port
//   dump_valid_o, dump_idx_o, dump_data_o, dump_ready_i
//                         register dump stream (valid/ready)
//   busy_o, done_o        status: LOAD/RUN/DUMP, DONE
//   cyc_cnt_o             RUN cycles elapsed in current or last run
// ---------------------------------------------------------------------------
module cpu_run_ctrl #(
    parameter int IM_DEPTH = 256,
    parameter int ADDR_W   = 8,
    parameter int REG_NUM  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [15:0]       run_len_i,
    input  logic              ld_valid_i,
    input  logic [31:0]       ld_data_i,
    input  logic              ld_last_i,
    output logic              ld_ready_o,
    output logic              im_we_o,
    output logic [ADDR_W-1:0] im_addr_o,
    output logic [31:0]       im_wdata_o,
    output logic              cpu_rst_n_o,
    output logic              cpu_en_o,
    output logic [4:0]        rf_raddr_o,
    input  logic [31:0]       rf_rdata_i,
    output logic              dump_valid_o,
    output logic [4:0]        dump_idx_o,
    output logic [31:0]       dump_data_o,
    input  logic              dump_ready_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [15:0]       cyc_cnt_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DUMP,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;   // next IM write address
    logic [15:0]       cnt_q, cnt_d;   // RUN cycles elapsed
    logic [15:0]       len_q, len_d;   // latched run length
    logic [4:0]        idx_q, idx_d;   // next register to dump

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, matching real hardware.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first; a path that
        // skips an assignment would otherwise infer a latch.
        state_d      = state_q;
        ptr_d        = ptr_q;
        cnt_d        = cnt_q;
        len_d        = len_q;
        idx_d        = idx_q;
        ld_ready_o   = 1'b0;
        im_we_o      = 1'b0;
        im_addr_o    = '0;
        im_wdata_o   = '0;
        cpu_rst_n_o  = 1'b0;
        cpu_en_o     = 1'b0;
        rf_raddr_o   = '0;
        dump_valid_o = 1'b0;
        dump_idx_o   = '0;
        dump_data_o  = '0;
        busy_o       = 1'b0;
        done_o       = 1'b0;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (state_q == S_DONE) begin
                    done_o      = 1'b1;
                    // Keep the CPU out of reset so its register file survives.
                    cpu_rst_n_o = 1'b1;
                end
                if (start_i) begin
                    len_d   = run_len_i;
                    ptr_d   = '0;
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = S_LOAD;
                end
            end

            S_LOAD: begin
                busy_o     = 1'b1;
                ld_ready_o = 1'b1;
                im_we_o    = ld_valid_i;
                im_addr_o  = ptr_q;
                im_wdata_o = ld_data_i;
                if (ld_valid_i) begin
                    ptr_d = ptr_q + 1'b1;
                    // A full memory ends the load even without a last marker.
                    if (ld_last_i || ptr_q == ADDR_W'(IM_DEPTH - 1)) begin
                        state_d = (len_q == '0) ? S_DUMP : S_RUN;
                    end
                end
            end

            S_RUN: begin
                busy_o      = 1'b1;
                cpu_rst_n_o = 1'b1;
                cpu_en_o    = 1'b1;
                cnt_d       = cnt_q + 16'd1;
                // This is the last enabled cycle once the count would hit len.
                if (cnt_q + 16'd1 == len_q) begin
                    state_d = S_DUMP;
                end
            end

            S_DUMP: begin
                busy_o       = 1'b1;
                cpu_rst_n_o  = 1'b1;
                dump_valid_o = 1'b1;
                rf_raddr_o   = idx_q;
                dump_idx_o   = idx_q;
                dump_data_o  = rf_rdata_i;
                if (dump_ready_i) begin
                    if (idx_q == 5'(REG_NUM - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign cyc_cnt_o = cnt_q;

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
- Sequencer that owns one complete run of the pipelined CPU.
- It loads instruction memory from a word stream, holds the CPU in reset while loading, then releases it.
- It enables the CPU for a programmed number of cycles, then freezes it.
- Finally it dumps all architectural registers through the register-file read port as a valid/ready stream. This replaces testbench-side memory preload and register peeking.

Parameters:
IM_DEPTH, 256, instruction memory depth in words
ADDR_W, 8, instruction memory word-address width (log2 IM_DEPTH)
REG_NUM, 32, registers dumped (indices 0..REG_NUM-1)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous, active-low reset
start_i  in  1  one-cycle start pulse; sampled in IDLE and DONE only
run_len_i  in  16  CPU run length in cycles; latched on accepted start
ld_valid_i  in  1  load word valid
ld_data_i  in  32  load word
ld_last_i  in  1  marks final load word
ld_ready_o  out  1  load word accepted when valid&ready
im_we_o  out  1  instruction memory write enable
im_addr_o  out  ADDR_W  instruction memory write address
im_wdata_o  out  32  instruction memory write data
cpu_rst_n_o  out  1  CPU reset, active-low
cpu_en_o  out  1  CPU global advance enable (PC/pipeline regs/RF writes)
rf_raddr_o  out  5  register-file read address (combinational read)
rf_rdata_i  in  32  register-file read data
dump_valid_o  out  1  dump beat valid
dump_idx_o  out  5  dump register index
dump_data_o  out  32  dump register value
dump_ready_i  in  1  dump sink ready
busy_o  out  1  high in LOAD, RUN, DUMP
done_o  out  1  high in DONE
cyc_cnt_o  out  16  RUN cycles elapsed in current or last run

Behaviour:
- Reset (rst_i=0, async): state=IDLE; load pointer=0, cycle counter=0, dump index=0. All outputs 0; cpu_rst_n_o=0. Reset mid-operation aborts immediately to IDLE. IM contents are not touched.
- States: IDLE, LOAD, RUN, DUMP, DONE.
- IDLE: ld_ready_o=0, cpu_rst_n_o=0, cpu_en_o=0. On start_i: latch run_len_i, clear pointer, counter and index, go to LOAD next cycle.
- LOAD outputs: ld_ready_o=1; im_we_o=ld_valid_i; im_addr_o=pointer; im_wdata_o=ld_data_i (all combinational). cpu_rst_n_o=0.
- LOAD pointer: increments on each accepted beat.
- LOAD exit: to RUN the cycle after an accepted beat with ld_last_i=1, or with pointer=IM_DEPTH-1 (capacity reached; ld_last_i ignored).
- LOAD partial program: words beyond the last loaded address keep their old contents.
- LOAD idle input: ld_valid_i may stay low indefinitely with no timeout.
- RUN: cpu_rst_n_o=1, cpu_en_o=1. Counter increments each cycle. When counter reaches latched length: cpu_en_o drops on the next edge and state goes to DUMP. CPU runs exactly run_len cycles.
- RUN with run_len=0: no RUN cycle; LOAD goes directly to DUMP with cpu_en_o never high.
- cpu_rst_n_o stays 1 from RUN through DONE so the register file is preserved.
- DUMP: cpu_en_o=0. rf_raddr_o=dump_idx_o=index; dump_data_o=rf_rdata_i; dump_valid_o=1.
- DUMP handshake: index advances only on valid&ready. Beat is held stable while ready is low.
- DUMP exit: handshake at index=REG_NUM-1 goes to DONE next cycle.
- DONE: done_o=1, all other handshakes idle, cyc_cnt_o holds final value. start_i restarts at LOAD, with cpu_rst_n_o returning to 0.
- start_i in LOAD/RUN/DUMP is ignored.
- rf_raddr_o is 0 outside DUMP.

Test Plan:
- Reset then start, run_len=100, stream 4 words with last on word 4 → im_we on addrs 0..3 with the streamed data. cpu_rst_n_o rises the cycle after word 4. cpu_en_o high exactly 100 cycles. cyc_cnt_o=100.
- Dump with dump_ready_i always 1, RF preloaded reg[i]=i*3 → 32 consecutive beats, idx 0..31, data 0..93. done_o rises the cycle after idx 31.
- Backpressure: drop dump_ready_i for 5 cycles at idx 7 → idx 7 and its data held constant. No beat lost or duplicated.
- Load gaps and overflow: random ld_valid_i gaps, IM_DEPTH=8, 10 words with no last → exactly 8 writes to addrs 0..7, ld_ready_o low from cycle 9, RUN entered.
- run_len=0 → LOAD goes straight to DUMP. cpu_en_o never asserted, cyc_cnt_o=0.
- Assert rst_i low mid-RUN at cycle 40, then release → outputs 0 asynchronously, state IDLE. A new start with run_len=10 completes a normal run.
